// File: rtl/return_addr_stack_pkg.sv
// Shared processor definitions used by the fetch stage.
//   AW            : ISA word address width
//   LINK_OFS      : distance from a call PC to its link (return) address
//   OP_JAL/JALR/JR: opcodes the fetch decoder matches to drive push/pop
//   ras_link()    : helper giving the link address for a call PC
package return_addr_stack_pkg;

   localparam int AW = 16;
   localparam logic [AW-1:0] LINK_OFS = 16'd2;

   typedef enum logic [3:0] {
      OP_JAL  = 4'h8,
      OP_JALR = 4'h9,
      OP_JR   = 4'hC
   } ras_op_e;

   // JR through R7 is the return idiom that pops the stack.
   localparam logic [2:0] RET_REG = 3'd7;

   function automatic logic [AW-1:0] ras_link(input logic [AW-1:0] pc);
      return pc + LINK_OFS;
   endfunction

endpackage

// File: rtl/return_addr_stack_pc_inc.sv
// PC+2 incrementer shared with the fetch stage.
//   i_pc       : current PC
//   o_pc_plus2 : i_pc + 2, truncated to AW bits (0xFFFE -> 0x0000)
module return_addr_stack_pc_inc
   import return_addr_stack_pkg::*;
(
   input  logic [AW-1:0] i_pc,
   output logic [AW-1:0] o_pc_plus2
);

   assign o_pc_plus2 = ras_link(i_pc);

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack for the fetch stage. Calls push their link address
// (call PC + 2); returns read the top entry as the predicted target.
// Storage is circular: pushing while full overwrites the oldest entry.
//   clk, rst_n  : clock, async active-low reset
//   push        : store link address of call_pc
//   call_pc     : PC of the call instruction
//   pop         : consume the top entry
//   flush       : discard all entries (wins over push/pop)
//   top_addr    : top entry, 0 while empty
//   top_valid   : stack non-empty
//   full        : count == DEPTH
//   underflow   : 1-cycle pulse, pop while empty
//   overflow    : 1-cycle pulse, push while full
module return_addr_stack
   import return_addr_stack_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [AW-1:0] call_pc,
   input  logic          pop,
   input  logic          flush,
   output logic [AW-1:0] top_addr,
   output logic          top_valid,
   output logic          full,
   output logic          underflow,
   output logic          overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wp;
   logic [CW-1:0] r_count;
   logic          r_underflow;
   logic          r_overflow;

   logic [AW-1:0] w_link;
   logic [PW-1:0] w_top_idx;
   logic          w_empty;
   logic          w_replace;
   logic          w_mem_we;
   logic [PW-1:0] w_mem_idx;

   return_addr_stack_pc_inc u_pc_inc (
      .i_pc       (call_pc),
      .o_pc_plus2 (w_link)
   );

   // Pointer arithmetic wraps naturally because DEPTH is a power of two.
   assign w_top_idx = r_wp - 1'b1;
   assign w_empty   = (r_count == '0);

   // Push+pop on a non-empty stack replaces the top in place; on an empty
   // stack it degenerates to a plain push.
   assign w_replace = push && pop && !w_empty;
   assign w_mem_we  = push && !flush;
   assign w_mem_idx = w_replace ? w_top_idx : r_wp;

   assign top_addr  = w_empty ? '0 : r_mem[w_top_idx];
   assign top_valid = !w_empty;
   assign full      = (r_count == FULL_CNT);
   assign underflow = r_underflow;
   assign overflow  = r_overflow;

   // Storage carries no reset; empty entries are masked by count.
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_idx] <= w_link;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp        <= '0;
         r_count     <= '0;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
         if (flush) begin
            r_wp    <= '0;
            r_count <= '0;
         end else if (w_replace) begin
            // top overwritten by the storage block; pointers unchanged
         end else if (push) begin
            r_wp <= r_wp + 1'b1;
            if (full) r_overflow <= 1'b1;
            else      r_count    <= r_count + 1'b1;
         end else if (pop) begin
            if (w_empty) begin
               r_underflow <= 1'b1;
            end else begin
               r_wp    <= r_wp - 1'b1;
               r_count <= r_count - 1'b1;
            end
         end
      end
   end

endmodule
